// File: rtl/seg7_scan_mux_pkg.sv
// Shared constants for the seven-segment scan multiplexer.
// Glyphs are active-high in {g,f,e,d,c,b,a} order.
package seg7_scan_mux_pkg;

   localparam logic [6:0] GLYPH_0     = 7'h3F;
   localparam logic [6:0] GLYPH_1     = 7'h06;
   localparam logic [6:0] GLYPH_2     = 7'h5B;
   localparam logic [6:0] GLYPH_3     = 7'h4F;
   localparam logic [6:0] GLYPH_4     = 7'h66;
   localparam logic [6:0] GLYPH_5     = 7'h6D;
   localparam logic [6:0] GLYPH_6     = 7'h7D;
   localparam logic [6:0] GLYPH_7     = 7'h07;
   localparam logic [6:0] GLYPH_8     = 7'h7F;
   localparam logic [6:0] GLYPH_9     = 7'h6F;
   localparam logic [6:0] GLYPH_U     = 7'h3E;
   localparam logic [6:0] GLYPH_P     = 7'h73;
   localparam logic [6:0] GLYPH_L     = 7'h38;
   localparam logic [6:0] GLYPH_BLANK = 7'h00;

   localparam logic [3:0] CODE_U     = 4'd10;
   localparam logic [3:0] CODE_P     = 4'd11;
   localparam logic [3:0] CODE_L     = 4'd12;
   localparam logic [3:0] CODE_BLANK = 4'd15;

   // Counter width that stays legal when the range collapses to one value.
   function automatic int cnt_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/seg7_glyph.sv
// Combinational 4-bit display code to 7-segment glyph decoder.
// Codes 13..15 decode to blank.
module seg7_glyph
   import seg7_scan_mux_pkg::*;
(
   input  logic [3:0] code,
   output logic [6:0] seg
);

   always_comb begin
      seg = GLYPH_BLANK;
      unique case (code)
         4'd0:    seg = GLYPH_0;
         4'd1:    seg = GLYPH_1;
         4'd2:    seg = GLYPH_2;
         4'd3:    seg = GLYPH_3;
         4'd4:    seg = GLYPH_4;
         4'd5:    seg = GLYPH_5;
         4'd6:    seg = GLYPH_6;
         4'd7:    seg = GLYPH_7;
         4'd8:    seg = GLYPH_8;
         4'd9:    seg = GLYPH_9;
         CODE_U:  seg = GLYPH_U;
         CODE_P:  seg = GLYPH_P;
         CODE_L:  seg = GLYPH_L;
         default: seg = GLYPH_BLANK;
      endcase
   end

endmodule

// File: rtl/seg7_scan_mux.sv
// Multiplexed seven-segment driver with frame-synchronous updates,
// per-digit blanking, blink and decimal-point control.
module seg7_scan_mux
   import seg7_scan_mux_pkg::*;
#(
   parameter int DIGITS     = 4,
   parameter int SCAN_DIV   = 50000,
   parameter int BLINK_DIV  = 64,
   parameter int ACTIVE_LOW = 0
)(
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  load,
   input  logic [4*DIGITS-1:0]   codes,
   input  logic [DIGITS-1:0]     blank_mask,
   input  logic [DIGITS-1:0]     blink_mask,
   input  logic [DIGITS-1:0]     dp_mask,
   output logic [6:0]            leds,
   output logic                  dp,
   output logic [DIGITS-1:0]     an
);

   localparam int IW = cnt_w(DIGITS);
   localparam int PW = cnt_w(SCAN_DIV);
   localparam int FW = cnt_w(BLINK_DIV);
   localparam logic POL = (ACTIVE_LOW != 0);

   logic [PW-1:0] pcnt;
   logic [IW-1:0] idx;
   logic [FW-1:0] fcnt;
   logic          phase;
   logic          pend;
   logic          tick;
   logic          wrap;

   logic [4*DIGITS-1:0] p_codes, s_codes;
   logic [DIGITS-1:0]   p_blank, s_blank;
   logic [DIGITS-1:0]   p_blink, s_blink;
   logic [DIGITS-1:0]   p_dp,    s_dp;

   logic [3:0]        code_sel;
   logic [6:0]        glyph;
   logic              vis;
   logic [DIGITS-1:0] an_d;
   logic [6:0]        leds_d;
   logic              dp_d;

   assign tick = (pcnt == PW'(SCAN_DIV - 1));
   assign wrap = tick && (idx == IW'(DIGITS - 1));

   always_ff @(posedge clk) begin
      if (reset) begin
         pcnt  <= '0;
         idx   <= '0;
         fcnt  <= '0;
         phase <= 1'b0;
      end else begin
         pcnt <= tick ? '0 : pcnt + PW'(1);
         if (tick)
            idx <= wrap ? '0 : idx + IW'(1);
         if (wrap) begin
            if (fcnt == FW'(BLINK_DIV - 1)) begin
               fcnt  <= '0;
               phase <= ~phase;
            end else begin
               fcnt <= fcnt + FW'(1);
            end
         end
      end
   end

   // Display reads only the shadow copy, swapped at frame boundaries.
   always_ff @(posedge clk) begin
      if (reset) begin
         pend    <= 1'b0;
         p_codes <= '0;
         p_blank <= '0;
         p_blink <= '0;
         p_dp    <= '0;
         s_codes <= {DIGITS{CODE_BLANK}};
         s_blank <= '0;
         s_blink <= '0;
         s_dp    <= '0;
      end else if (wrap) begin
         pend <= 1'b0;
         if (load) begin
            s_codes <= codes;
            s_blank <= blank_mask;
            s_blink <= blink_mask;
            s_dp    <= dp_mask;
         end else if (pend) begin
            s_codes <= p_codes;
            s_blank <= p_blank;
            s_blink <= p_blink;
            s_dp    <= p_dp;
         end
      end else if (load) begin
         pend    <= 1'b1;
         p_codes <= codes;
         p_blank <= blank_mask;
         p_blink <= blink_mask;
         p_dp    <= dp_mask;
      end
   end

   always_comb begin
      code_sel = s_codes[4*idx +: 4];
   end

   seg7_glyph u_glyph (
      .code (code_sel),
      .seg  (glyph)
   );

   always_comb begin
      vis    = !s_blank[idx] && !(s_blink[idx] && phase);
      an_d   = '0;
      leds_d = '0;
      dp_d   = 1'b0;
      if (vis) begin
         an_d[idx] = 1'b1;
         leds_d    = glyph;
         dp_d      = s_dp[idx];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         an   <= {DIGITS{POL}};
         leds <= {7{POL}};
         dp   <= POL;
      end else begin
         an   <= an_d ^ {DIGITS{POL}};
         leds <= leds_d ^ {7{POL}};
         dp   <= dp_d ^ POL;
      end
   end

endmodule

// File: tb/tb_seg7_scan_mux.sv
// Directed bench for seg7_scan_mux; a second instance runs with
// ACTIVE_LOW=1 on the same stimulus.
module tb_seg7_scan_mux;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        load = 1'b0;
   logic [15:0] codes = '0;
   logic [3:0]  blank_mask = '0;
   logic [3:0]  blink_mask = '0;
   logic [3:0]  dp_mask = '0;
   logic [6:0]  leds, leds_n;
   logic        dp, dp_n;
   logic [3:0]  an, an_n;

   int total = 0;
   int bad = 0;
   int cyc = 0;

   always #5 clk = ~clk;

   seg7_scan_mux #(
      .DIGITS(4), .SCAN_DIV(4), .BLINK_DIV(2), .ACTIVE_LOW(0)
   ) dut (
      .clk(clk), .reset(reset), .load(load), .codes(codes),
      .blank_mask(blank_mask), .blink_mask(blink_mask),
      .dp_mask(dp_mask), .leds(leds), .dp(dp), .an(an)
   );

   seg7_scan_mux #(
      .DIGITS(4), .SCAN_DIV(4), .BLINK_DIV(2), .ACTIVE_LOW(1)
   ) dut_n (
      .clk(clk), .reset(reset), .load(load), .codes(codes),
      .blank_mask(blank_mask), .blink_mask(blink_mask),
      .dp_mask(dp_mask), .leds(leds_n), .dp(dp_n), .an(an_n)
   );

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic run_to(input int k);
      while (cyc < k) step();
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      total++;
      if (an !== 4'b0000 || leds !== 7'h00 || dp !== 1'b0) begin
         bad++;
         $display("FAIL reset_hi got an=%b leds=%h dp=%b want 0000/00/0",
                  an, leds, dp);
      end
      total++;
      if (an_n !== 4'b1111 || leds_n !== 7'h7F || dp_n !== 1'b1) begin
         bad++;
         $display("FAIL reset_lo got an=%b leds=%h dp=%b want 1111/7f/1",
                  an_n, leds_n, dp_n);
      end
      reset = 1'b0;
      cyc = 0;
      for (int k = 1; k <= 16; k++) begin
         step();
         total++;
         if (leds !== 7'h00 || dp !== 1'b0) begin
            bad++;
            $display("FAIL first_frame cyc=%0d got leds=%h dp=%b want 00/0",
                     cyc, leds, dp);
         end
      end
   endtask

   task automatic test_basic();
      logic [6:0] g [4];
      logic [3:0] ea;
      logic [6:0] el;
      int d;
      g = '{7'h3F, 7'h06, 7'h5B, 7'h4F};
      codes = 16'h3210;
      blank_mask = '0;
      blink_mask = '0;
      dp_mask = '0;
      load = 1'b1;
      step();
      load = 1'b0;
      run_to(32);
      for (int k = 33; k <= 64; k++) begin
         step();
         d = ((cyc - 1) / 4) % 4;
         ea = 4'b0001 << d;
         el = g[d];
         total++;
         if (an !== ea || leds !== el || dp !== 1'b0) begin
            bad++;
            $display("FAIL basic cyc=%0d got %b/%h/%b want %b/%h/0",
                     cyc, an, leds, dp, ea, el);
         end
         total++;
         if (an_n !== ~ea || leds_n !== ~el || dp_n !== 1'b1) begin
            bad++;
            $display("FAIL basic_lo cyc=%0d got %b/%h/%b want %b/%h/1",
                     cyc, an_n, leds_n, dp_n, ~ea, ~el);
         end
      end
   endtask

   task automatic test_glyphs();
      logic [6:0] g [4];
      logic [3:0] ea;
      logic [6:0] el;
      logic       ed;
      int d;
      g = '{7'h3E, 7'h73, 7'h38, 7'h00};
      codes = 16'hDCBA;
      dp_mask = 4'b0100;
      load = 1'b1;
      step();
      load = 1'b0;
      run_to(80);
      for (int k = 81; k <= 96; k++) begin
         step();
         d = ((cyc - 1) / 4) % 4;
         ea = 4'b0001 << d;
         el = g[d];
         ed = (d == 2);
         total++;
         if (an !== ea || leds !== el || dp !== ed) begin
            bad++;
            $display("FAIL glyphs cyc=%0d got %b/%h/%b want %b/%h/%b",
                     cyc, an, leds, dp, ea, el, ed);
         end
         total++;
         if (dp_n !== ~ed) begin
            bad++;
            $display("FAIL glyphs_dp_lo cyc=%0d got %b want %b",
                     cyc, dp_n, ~ed);
         end
      end
   endtask

   task automatic test_blink();
      logic [6:0] g [4];
      logic [3:0] ea;
      logic [6:0] el;
      int d, m, ph;
      g = '{7'h3F, 7'h06, 7'h5B, 7'h4F};
      codes = 16'h3210;
      blink_mask = 4'b0001;
      blank_mask = 4'b1000;
      dp_mask = '0;
      load = 1'b1;
      step();
      load = 1'b0;
      run_to(112);
      for (int k = 113; k <= 176; k++) begin
         step();
         d = ((cyc - 1) / 4) % 4;
         m = (cyc - 1) / 16;
         ph = (m / 2) % 2;
         ea = 4'b0001 << d;
         el = g[d];
         if (d == 3 || (d == 0 && ph == 1)) begin
            ea = 4'b0000;
            el = 7'h00;
         end
         total++;
         if (an !== ea || leds !== el || dp !== 1'b0) begin
            bad++;
            $display("FAIL blink cyc=%0d got %b/%h/%b want %b/%h/0",
                     cyc, an, leds, dp, ea, el);
         end
      end
   endtask

   task automatic test_tear_free();
      codes = 16'h1111;
      blink_mask = '0;
      blank_mask = '0;
      run_to(180);
      load = 1'b1;
      step();
      load = 1'b0;
      total++;
      if (an !== 4'b0010 || leds !== 7'h06) begin
         bad++;
         $display("FAIL tear_old1 got %b/%h want 0010/06", an, leds);
      end
      run_to(184);
      codes = 16'h2222;
      load = 1'b1;
      step();
      load = 1'b0;
      run_to(189);
      total++;
      if (an !== 4'b0000 || leds !== 7'h00) begin
         bad++;
         $display("FAIL tear_old3 got %b/%h want 0000/00", an, leds);
      end
      for (int k = 190; k <= 224; k++) begin
         step();
         if (cyc == 207) begin
            codes = 16'h4444;
            load = 1'b1;
         end
         if (cyc == 208) load = 1'b0;
         if (cyc >= 193) begin
            total++;
            if (an !== (4'b0001 << (((cyc - 1) / 4) % 4)) ||
                leds !== ((cyc <= 208) ? 7'h5B : 7'h66)) begin
               bad++;
               $display("FAIL tear_new cyc=%0d got %b/%h want digit %0d %s",
                        cyc, an, leds, ((cyc - 1) / 4) % 4,
                        (cyc <= 208) ? "5b" : "66");
            end
         end
      end
   endtask

   task automatic test_reset_mid();
      run_to(232);
      codes = 16'h8888;
      load = 1'b1;
      step();
      load = 1'b0;
      step();
      reset = 1'b1;
      step();
      total++;
      if (an !== 4'b0000 || leds !== 7'h00 || dp !== 1'b0) begin
         bad++;
         $display("FAIL mid_reset got %b/%h/%b want 0000/00/0",
                  an, leds, dp);
      end
      total++;
      if (an_n !== 4'b1111 || leds_n !== 7'h7F || dp_n !== 1'b1) begin
         bad++;
         $display("FAIL mid_reset_lo got %b/%h/%b want 1111/7f/1",
                  an_n, leds_n, dp_n);
      end
      reset = 1'b0;
      cyc = 0;
      for (int k = 1; k <= 32; k++) begin
         step();
         total++;
         if (an !== (4'b0001 << (((cyc - 1) / 4) % 4)) ||
             leds !== 7'h00) begin
            bad++;
            $display("FAIL after_reset cyc=%0d got %b/%h want digit %0d/00",
                     cyc, an, leds, ((cyc - 1) / 4) % 4);
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_basic();
      test_glyphs();
      test_blink();
      test_tear_free();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
